// File: rtl/cache_2way_wb_if.sv
// Processor-side request bus plus block-wide memory bus of the 2-way write-back cache.
// Latency: none (wiring only).
// Backpressure: proc_stall holds the processor; mem_ready completes a memory request.
interface cache_2way_wb_if #(
    parameter int ADDR_W    = 30,
    parameter int WORD_BITS = 2
);
    localparam int BLK_W   = 32 << WORD_BITS;
    localparam int MADDR_W = ADDR_W - WORD_BITS;

    logic                proc_read;
    logic                proc_write;
    logic [ADDR_W-1:0]   proc_addr;
    logic [31:0]         proc_wdata;
    logic                proc_stall;
    logic [31:0]         proc_rdata;
    logic                mem_read;
    logic                mem_write;
    logic [MADDR_W-1:0]  mem_addr;
    logic [BLK_W-1:0]    mem_wdata;
    logic [BLK_W-1:0]    mem_rdata;
    logic                mem_ready;

    // Cache side: serves the processor, drives the memory request.
    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    // Environment side: processor and memory.
    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_2way_wb.sv
// 2-way set-associative write-back, write-allocate data cache with LRU replacement.
// Latency: hits complete combinationally (0 wait cycles); misses stall through WRITEBACK/ALLOCATE.
// Backpressure: proc_stall high until the request completes; memory transfers wait for mem_ready.
module cache_2way_wb #(
    parameter int ADDR_W    = 30,
    parameter int SET_BITS  = 2,
    parameter int WORD_BITS = 2
) (
    input  logic            clk,
    input  logic            proc_reset,
    cache_2way_wb_if.slave  bus
);
    localparam int TAG_W   = ADDR_W - SET_BITS - WORD_BITS;
    localparam int BLK_W   = 32 << WORD_BITS;
    localparam int MADDR_W = ADDR_W - WORD_BITS;
    localparam int SETS    = 1 << SET_BITS;

    typedef enum logic [1:0] {COMPARE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2} state_t;

    state_t                state, state_nxt;
    logic [BLK_W-1:0]      data_arr [2][SETS];
    logic [TAG_W-1:0]      tag_arr  [2][SETS];
    logic [SETS-1:0]       valid    [2];
    logic [SETS-1:0]       dirty    [2];
    logic [SETS-1:0]       lru;         // per set: index of the least recently used way
    logic                  victim_way;

    logic                  mem_read_q, mem_write_q;
    logic [MADDR_W-1:0]    mem_addr_q;
    logic [BLK_W-1:0]      mem_wdata_q;

    logic [TAG_W-1:0]      req_tag;
    logic [SET_BITS-1:0]   req_set;
    logic [WORD_BITS-1:0]  req_word;
    logic                  req, is_write;
    logic [1:0]            hit_w;
    logic                  hit, hit_way, victim_c, victim_dirty_c;
    logic [BLK_W-1:0]      hit_blk, wr_blk;

    assign req_tag  = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign req_set  = bus.proc_addr[WORD_BITS +: SET_BITS];
    assign req_word = bus.proc_addr[WORD_BITS-1:0];
    assign req      = bus.proc_read | bus.proc_write;
    assign is_write = bus.proc_write;   // read+write together behaves as a write

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // Tag lookup, victim choice and processor-side responses.
    always_comb begin
        hit_w[0]       = valid[0][req_set] && (tag_arr[0][req_set] == req_tag);
        hit_w[1]       = valid[1][req_set] && (tag_arr[1][req_set] == req_tag);
        hit            = (state == COMPARE) && req && (hit_w != 2'b00);
        hit_way        = !hit_w[0];
        // First invalid way (way0 preferred), else the LRU way.
        if (!valid[0][req_set])      victim_c = 1'b0;
        else if (!valid[1][req_set]) victim_c = 1'b1;
        else                         victim_c = lru[req_set];
        victim_dirty_c = valid[victim_c][req_set] && dirty[victim_c][req_set];
        hit_blk        = data_arr[hit_way][req_set];
        wr_blk         = hit_blk;
        wr_blk[{req_word, 5'd0} +: 32] = bus.proc_wdata;
        bus.proc_stall = req && !hit;
        bus.proc_rdata = (hit && !is_write) ? hit_blk[{req_word, 5'd0} +: 32] : 32'd0;
    end

    // Miss FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            COMPARE:   if (req && !hit) state_nxt = victim_dirty_c ? WRITEBACK : ALLOCATE;
            WRITEBACK: if (bus.mem_ready) state_nxt = ALLOCATE;
            ALLOCATE:  if (bus.mem_ready) state_nxt = COMPARE;
            default:   state_nxt = COMPARE;
        endcase
    end

    // Miss FSM state register.
    always_ff @(posedge clk) begin
        if (proc_reset) state <= COMPARE;
        else            state <= state_nxt;
    end

    // Line status bits, LRU and registered memory handshake.
    always_ff @(posedge clk) begin
        if (proc_reset) begin
            valid[0]    <= '0;
            valid[1]    <= '0;
            dirty[0]    <= '0;
            dirty[1]    <= '0;
            lru         <= '0;
            victim_way  <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state)
                COMPARE: begin
                    if (hit) begin
                        lru[req_set] <= ~hit_way;
                        if (is_write) dirty[hit_way][req_set] <= 1'b1;
                    end else if (req) begin
                        victim_way <= victim_c;
                        if (victim_dirty_c) begin
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= {tag_arr[victim_c][req_set], req_set};
                            mem_wdata_q <= data_arr[victim_c][req_set];
                        end else begin
                            mem_read_q <= 1'b1;
                            mem_addr_q <= bus.proc_addr[ADDR_W-1:WORD_BITS];
                        end
                    end
                end
                WRITEBACK: begin
                    // Hand straight over to the fill without an idle cycle.
                    if (bus.mem_ready) begin
                        dirty[victim_way][req_set] <= 1'b0;
                        mem_write_q <= 1'b0;
                        mem_read_q  <= 1'b1;
                        mem_addr_q  <= bus.proc_addr[ADDR_W-1:WORD_BITS];
                    end
                end
                ALLOCATE: begin
                    if (bus.mem_ready) begin
                        valid[victim_way][req_set] <= 1'b1;
                        dirty[victim_way][req_set] <= 1'b0;
                        mem_read_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and tag arrays: write hits and fills; contents survive reset.
    always_ff @(posedge clk) begin
        if (!proc_reset) begin
            if (hit && is_write)
                data_arr[hit_way][req_set] <= wr_blk;
            if (state == ALLOCATE && bus.mem_ready) begin
                data_arr[victim_way][req_set] <= bus.mem_rdata;
                tag_arr[victim_way][req_set]  <= req_tag;
            end
        end
    end
endmodule

// File: doc/cache_2way_wb.md
Name: cache_2way_wb

Overview:
Parametrised 2-way set-associative, write-back, write-allocate data cache. It sits between the 32-bit-word processor interface and the block-wide memory interface, in the same slot as the direct-mapped cache. It adds configurable set count and block size, LRU replacement and an explicit miss FSM with registered memory handshake outputs.

Parameters:
ADDR_W, 30, processor word-address width
SET_BITS, 2, log2 of set count (default 4 sets, 8 lines in total)
WORD_BITS, 2, log2 of words per block (default 4 words = 128 bits)
Derived, not overridable: TAG_W = ADDR_W-SET_BITS-WORD_BITS; BLK_W = 32<<WORD_BITS; MADDR_W = ADDR_W-WORD_BITS

Ports:
clk  in  1  clock; all state updates on the rising edge
proc_reset  in  1  synchronous, active-high reset
proc_read  in  1  read request, held until proc_stall is low
proc_write  in  1  write request, held until proc_stall is low
proc_addr  in  ADDR_W  word address: tag | set | word
proc_wdata  in  32  write data
proc_stall  out  1  request not yet completed
proc_rdata  out  32  read data, valid when proc_read=1 and proc_stall=0
mem_read  out  1  block read request (registered)
mem_write  out  1  block write request (registered)
mem_addr  out  MADDR_W  block address (registered)
mem_wdata  out  BLK_W  writeback block (registered)
mem_rdata  in  BLK_W  fill data, valid when mem_ready=1
mem_ready  in  1  memory completes the current request this cycle

Behaviour:
- Reset: one clock with proc_reset=1 clears every valid, dirty and LRU bit and sets the FSM to COMPARE. It also clears mem_read, mem_write, mem_addr and mem_wdata. Data and tag arrays are not cleared.
- Reset during WRITEBACK or ALLOCATE aborts the transfer: memory outputs are 0 from the next cycle and a partial writeback is discarded.
- Request decoding:
  - proc_read=1 and proc_write=1 together is treated as a write.
  - With no request, proc_stall=0 and no state changes.
- Hit: in COMPARE, a way has valid=1 and a matching tag.
  - proc_stall=0 combinationally in the same cycle, so there are zero wait cycles.
  - A read returns the selected word on proc_rdata.
  - A write updates that word and sets dirty at the edge.
  - Either access marks the other way as LRU.
- Otherwise proc_stall=1, and proc_rdata=0 when not a read hit.
- Victim selection:
  - The first invalid way, with way0 preferred.
  - If both ways are valid, the LRU way.
- FSM states:
  - COMPARE: on a miss, go to WRITEBACK if the victim is valid and dirty, else to ALLOCATE. Load the memory output registers on the same edge.
  - WRITEBACK: mem_write=1, mem_addr={victim tag, set}, mem_wdata=victim block.
    - All held stable until mem_ready=1.
    - On that edge: clear victim dirty, go to ALLOCATE, load mem_read=1 and mem_addr=proc_addr[ADDR_W-1:WORD_BITS].
  - ALLOCATE: mem_read=1 held until mem_ready=1.
    - On that edge: victim data<=mem_rdata, tag<=request tag, valid<=1, dirty<=0, mem_read<=0, return to COMPARE.
    - The request then hits the next cycle.
- mem_read and mem_write are never both 1.
- Memory outputs drop on the edge where mem_ready is sampled high.
- Clean-miss latency: miss at cycle t, mem_read high from t+1; if mem_ready arrives at t+1+k, stall is low at t+2+k.
- A dirty miss adds the writeback handshake duration plus 0 extra cycles (direct WRITEBACK->ALLOCATE handoff).
- The processor must hold address, data and request while stalled. Changing them mid-miss is undefined.
- mem_ready while no memory request is outstanding is ignored.

Test Plan:
1. Reset, then read 0x10 (set0, tag1, word0), mem_ready 2 cycles after mem_read rises, mem_rdata=0x…_44_33_22_11 words -> mem_read=1 with mem_addr=0x04; proc_stall low one cycle after the fill; proc_rdata=word0; no mem_write.
2. After fill, write 0x11 data 0xDEADBEEF, then read 0x11 -> both complete with proc_stall=0 in the request cycle; rdata=0xDEADBEEF; no memory traffic.
3. Read 0x10, then 0x20 (same set, tag2), then alternate 0x10/0x20 ×4 -> exactly two misses in total, both ways valid.
4. Dirty 0x11 (tag1, way0), read 0x20, read 0x10, then read 0x30 -> victim is tag2 (clean, LRU): no mem_write, mem_read addr 0x0C. Then read 0x40 -> victim tag1 dirty: mem_write=1, mem_addr=0x04, mem_wdata[63:32]=0xDEADBEEF, followed immediately by mem_read addr 0x10.
5. Assert proc_reset for one cycle during WRITEBACK while mem_ready=0 -> mem_write=0 the next cycle; a subsequent read of 0x10 misses (all lines invalid).
6. No request for 3 cycles -> proc_stall=0 and mem_read=mem_write=0. Then proc_read=proc_write=1 to 0x10 after fill -> handled as a write hit, dirty set.
